// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector:
// fill-counter width helper, default pattern and overlap mode encodings.
package seq_det_pkg;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_mode_e;

  // Fill runs 0..n inclusive, so it needs one more code than n itself.
  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; built only when
// SEQ_DET_MATCH_COUNT_EN is defined.
`ifdef SEQ_DET_MATCH_COUNT_EN
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Holds at all-ones instead of wrapping back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/seq_detector_param.sv
// Moore serial pattern detector with programmable pattern and overlap mode.
// Optional saturating match counter enabled by macro SEQ_DET_MATCH_COUNT_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PATTERN_W = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 x,
  input  logic                 in_valid,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic                 overlap,
  input  logic                 clear,
  output logic                 op,
  output logic [CNT_W-1:0]     match_count
);

  localparam int FILL_W = fill_w(PATTERN_W);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PATTERN_W);

  logic [PATTERN_W-1:0] hist;
  logic [FILL_W-1:0]    fill;
  logic [PATTERN_W-1:0] next_hist;
  logic [FILL_W-1:0]    next_fill;
  logic                 match;

  // A match needs a full window of valid bits; clear suppresses it outright.
  always_comb begin
    next_hist = {hist[PATTERN_W-2:0], x};
    next_fill = (fill == FULL) ? fill : fill + 1'b1;
    match     = in_valid && !clear && (next_fill == FULL) && (next_hist == pattern);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
      op   <= 1'b0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
      op   <= 1'b0;
    end else if (in_valid) begin
      hist <= next_hist;
      op   <= match;
      // Non-overlapping mode restarts the window so the next match needs fresh bits.
      fill <= (match && (ovl_mode_e'(overlap) == OVL_OFF)) ? '0 : next_fill;
    end else begin
      op <= 1'b0;
    end
  end

`ifdef SEQ_DET_MATCH_COUNT_EN
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (match),
    .clr  (clear),
    .count(match_count)
  );
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed scoreboard bench for seq_detector_param: a 4-bit instance for the
// main streams and a 2-bit / 2-bit-counter instance for counter saturation.
module tb_seq_detector_param;
  import seq_det_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       x4, v4, c4, ovl4, op4;
  logic [3:0] p4;
  logic [7:0] cnt4;
  logic       x2, v2, c2, ovl2, op2;
  logic [1:0] p2;
  logic [1:0] cnt2;

  typedef struct {
    bit   sel;
    logic op;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PATTERN_W(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .x(x4), .in_valid(v4), .pattern(p4),
    .overlap(ovl4), .clear(c4), .op(op4), .match_count(cnt4)
  );

  seq_detector_param #(.PATTERN_W(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .x(x2), .in_valid(v2), .pattern(p2),
    .overlap(ovl2), .clear(c2), .op(op2), .match_count(cnt2)
  );

  function automatic int exp_cnt(input int n);
`ifdef SEQ_DET_MATCH_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      if (e.sel) check("op2", int'(op2), int'(e.op));
      else       check("op4", int'(op4), int'(e.op));
    end
  endtask

  // Drive one cycle on the selected instance, queue its expected op, sample after the edge.
  task automatic applyStimulus(input bit sel, input logic xv, input logic v,
                               input logic c, input logic exp_op);
    exp_t e;
    v4 = 1'b0; c4 = 1'b0; v2 = 1'b0; c2 = 1'b0;
    if (sel) begin x2 = xv; v2 = v; c2 = c; end
    else     begin x4 = xv; v4 = v; c4 = c; end
    e.sel = sel;
    e.op  = exp_op;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runStream(input logic [6:0] bits, input logic [6:0] exps, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b0, bits[i], 1'b1, 1'b0, exps[i]);
  endtask

  initial begin
    rst_n = 1'b0;
    x4 = 1'b0; v4 = 1'b0; c4 = 1'b0; ovl4 = OVL_ON;  p4 = DEFAULT_PATTERN;
    x2 = 1'b0; v2 = 1'b0; c2 = 1'b0; ovl2 = OVL_ON;  p2 = 2'b11;
    #12;
    check("reset_op", int'(op4), 0);
    check("reset_cnt", int'(cnt4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] overlapping stream 1011011");
    runStream(7'b1011011, 7'b0001001, 7);
    check("ovl_cnt", int'(cnt4), exp_cnt(2));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clear_cnt_a", int'(cnt4), 0);

    $display("[TB] non-overlapping stream 1011011");
    ovl4 = OVL_OFF;
    runStream(7'b1011011, 7'b0001000, 7);
    check("novl_cnt", int'(cnt4), exp_cnt(1));
    check("novl_fill", int'(dut4.fill), 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] stream with valid gaps");
    ovl4 = OVL_ON;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("gap_cnt", int'(cnt4), exp_cnt(1));

    $display("[TB] asynchronous reset mid-stream");
    runStream(7'b0000101, 7'b0000000, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_op", int'(op4), 0);
    check("async_cnt", int'(cnt4), 0);
    check("async_fill", int'(dut4.fill), 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runStream(7'b0001011, 7'b0000001, 4);
    check("post_rst_cnt", int'(cnt4), exp_cnt(1));

    $display("[TB] clear coinciding with final pattern bit");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    runStream(7'b0000101, 7'b0000000, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_hist", int'(dut4.hist), 0);
    check("clr_fill", int'(dut4.fill), 0);
    check("clr_cnt", int'(cnt4), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("clr_fill_next", int'(dut4.fill), 1);

    $display("[TB] two-bit pattern counter saturation");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, (i == 0) ? 1'b0 : 1'b1);
    check("sat_cnt", int'(cnt2), exp_cnt(3));

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
